// File: rtl/sram64kb_ctrl_if.sv
// Requester-side bus for sram64kb_ctrl: one instance per requester port.
//   req   : request, held with its fields until gnt
//   we    : 1 = write, 0 = read
//   addr  : byte address, [15:9] bank, [8:0] word
//   wdata : write data
//   gnt   : combinational accept strobe; fields are captured on this edge
//   done  : one-cycle completion pulse
//   rdata : read data, valid with done, held until the port's next read done
// Modports: master (requester side), slave (controller side).
interface sram64kb_ctrl_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          done;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/sram64kb_ctrl.sv
// Two-requester controller for a 64 KB SRAM array built from 128 banks of 512x8.
// Arbitrates two request ports, decodes the byte address into a one-hot active-low
// bank select plus a 9-bit word address, and sequences SETUP/STROBE/HOLD around
// MEM_CE. Read data returns 4 cycles after grant.
//
// Optional feature macro: SRAM64KB_CTRL_RR_ARB_EN
//   defined   : round-robin arbitration between the two ports
//   undefined : fixed priority, port 0 always wins
//
// Ports:
//   i_clk       : clock
//   i_rstn      : synchronous active-low reset
//   p0_bus      : requester port 0 (slave modport)
//   p1_bus      : requester port 1 (slave modport)
//   o_busy      : high whenever the FSM is not idle
//   o_mem_addr  : word address to all banks
//   o_mem_ce    : access strobe, high for the STROBE cycle only
//   o_mem_web   : write enable, active-low
//   o_mem_oeb   : output enable per bank, one-hot active-low
//   o_mem_csb   : chip select per bank, one-hot active-low
//   o_mem_idata : write data to the array
//   i_mem_odata : OR-combined read data from the array
module sram64kb_ctrl #(
  parameter int unsigned NBANK   = 128,
  parameter int unsigned BANK_AW = 7,
  parameter int unsigned WORD_AW = 9,
  parameter int unsigned DW      = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  sram64kb_ctrl_if.slave     p0_bus,
  sram64kb_ctrl_if.slave     p1_bus,
  output logic               o_busy,
  output logic [WORD_AW-1:0] o_mem_addr,
  output logic               o_mem_ce,
  output logic               o_mem_web,
  output logic [NBANK-1:0]   o_mem_oeb,
  output logic [NBANK-1:0]   o_mem_csb,
  output logic [DW-1:0]      o_mem_idata,
  input  logic [DW-1:0]      i_mem_odata
);

  localparam int unsigned AW = BANK_AW + WORD_AW;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic               r_port;       // granted port of the access in flight
  logic               r_we;
  logic [WORD_AW-1:0] r_mem_addr;
  logic               r_mem_ce;
  logic               r_mem_web;
  logic [NBANK-1:0]   r_mem_oeb;
  logic [NBANK-1:0]   r_mem_csb;
  logic [DW-1:0]      r_mem_idata;
  logic               r_done0;
  logic               r_done1;
  logic [DW-1:0]      r_rdata0;
  logic [DW-1:0]      r_rdata1;

  logic               w_idle;
  logic               w_prio0;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_sel_we;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_wdata;
  logic [BANK_AW-1:0] w_bank;
  logic [NBANK-1:0]   w_bank_oh;

`ifdef SRAM64KB_CTRL_RR_ARB_EN
  // 1 when port 1 took the last grant; reset value gives port 0 priority.
  logic r_last_p1;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_last_p1 <= 1'b1;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_p1 <= w_gnt1;
    end
  end

  assign w_prio0 = r_last_p1;
`else
  assign w_prio0 = 1'b1;
`endif

  // Grants are only offered in IDLE and never while reset is being applied.
  assign w_idle = (r_state == StIdle) && i_rstn;
  assign w_gnt0 = w_idle && p0_bus.req && (!p1_bus.req || w_prio0);
  assign w_gnt1 = w_idle && p1_bus.req && !w_gnt0;

  assign w_sel_we    = w_gnt1 ? p1_bus.we    : p0_bus.we;
  assign w_sel_addr  = w_gnt1 ? p1_bus.addr  : p0_bus.addr;
  assign w_sel_wdata = w_gnt1 ? p1_bus.wdata : p0_bus.wdata;
  assign w_bank      = w_sel_addr[AW-1:WORD_AW];
  assign w_bank_oh   = {{(NBANK-1){1'b0}}, 1'b1} << w_bank;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_gnt0 || w_gnt1) w_state_nxt = StSetup;
      StSetup:  w_state_nxt = StStrobe;
      StStrobe: w_state_nxt = StHold;
      StHold:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= StIdle;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_web   <= 1'b1;
      r_mem_oeb   <= '1;
      r_mem_csb   <= '1;
      r_mem_idata <= '0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Array-side signals are set up on the grant edge so they are
          // already stable throughout SETUP.
          if (w_gnt0 || w_gnt1) begin
            r_port      <= w_gnt1;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr[WORD_AW-1:0];
            r_mem_csb   <= ~w_bank_oh;
            r_mem_oeb   <= w_sel_we ? {NBANK{1'b1}} : ~w_bank_oh;
            r_mem_web   <= ~w_sel_we;
            r_mem_idata <= w_sel_wdata;
          end
        end
        StSetup:  r_mem_ce <= 1'b1;
        StStrobe: r_mem_ce <= 1'b0;
        StHold: begin
          r_mem_csb <= '1;
          r_mem_oeb <= '1;
          r_mem_web <= 1'b1;
          if (r_port) r_done1 <= 1'b1;
          else        r_done0 <= 1'b1;
          if (!r_we) begin
            if (r_port) r_rdata1 <= i_mem_odata;
            else        r_rdata0 <= i_mem_odata;
          end
        end
        default: ;
      endcase
    end
  end

  assign p0_bus.gnt   = w_gnt0;
  assign p1_bus.gnt   = w_gnt1;
  assign p0_bus.done  = r_done0;
  assign p1_bus.done  = r_done1;
  assign p0_bus.rdata = r_rdata0;
  assign p1_bus.rdata = r_rdata1;

  assign o_busy      = (r_state != StIdle);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_ce    = r_mem_ce;
  assign o_mem_web   = r_mem_web;
  assign o_mem_oeb   = r_mem_oeb;
  assign o_mem_csb   = r_mem_csb;
  assign o_mem_idata = r_mem_idata;

endmodule
